// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the single sideband transmitter among the LTSM
// substate engines, with a forced inter-message gap and an ack-timeout abort.
module sb_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MSG_W       = 64,
    parameter int GAP_CYC     = 2,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                       clk_100MHz,
    input  logic                       reset_n,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*MSG_W-1:0]   req_msg_i,
    output logic [NUM_REQ-1:0]         req_ack_o,
    output logic [MSG_W-1:0]           tx_msg_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ack_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int ACK_W = $clog2(ACK_TIMEOUT);

    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       GAP_LAST = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] win_next;
    logic             win_found;
    logic [ACK_W-1:0] ack_cnt;
    logic [3:0]       gap_cnt;
    logic             send_done;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign win_next  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    // Ack takes priority: a same-edge ack still terminates the message cleanly.
    assign send_done = tx_ack_i || (ack_cnt == ACK_LAST);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            ack_cnt    <= '0;
            gap_cnt    <= '0;
            tx_valid_o <= 1'b0;
            tx_msg_o   <= '0;
            req_ack_o  <= '0;
            grant_id_o <= '0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            req_ack_o <= '0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_i && win_found) begin
                        state      <= ST_SEND;
                        tx_valid_o <= 1'b1;
                        busy_o     <= 1'b1;
                        tx_msg_o   <= req_msg_i[win_idx*MSG_W +: MSG_W];
                        grant_id_o <= win_idx;
                        rr_ptr     <= win_next;
                        ack_cnt    <= '0;
                    end
                end
                ST_SEND: begin
                    if (send_done) begin
                        tx_valid_o             <= 1'b0;
                        req_ack_o[grant_id_o]  <= 1'b1;
                        timeout_o              <= !tx_ack_i;
                        gap_cnt                <= '0;
                        if (GAP_CYC == 0) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= ST_GAP;
                        end
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    tx_valid_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule
